// File: rtl/state_word_demux.sv
// state_word_demux: captures one 320-bit state and streams its five words to one of two consumers
module state_word_demux #(
  parameter int NB_WORDS = 5,
  parameter int WORD_W   = 64
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       load_i,
  input  logic                       sel_i,
  input  logic [NB_WORDS*WORD_W-1:0] state_i,
  output logic                       ready_o,
  output logic [WORD_W-1:0]          word_o,
  output logic [2:0]                 idx_o,
  output logic                       valid1_o,
  input  logic                       ready1_i,
  output logic                       valid2_o,
  input  logic                       ready2_i,
  output logic                       done_o
);
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [2:0] LAST = 3'(NB_WORDS - 1);
  state_t                     r_st, w_st;
  logic [NB_WORDS*WORD_W-1:0] r_buf, w_buf;
  logic                       r_sel, w_sel;
  logic [2:0]                 r_idx, w_idx;
  logic                       r_done, w_done;
  logic                       w_xfer;
  assign w_xfer   = (r_st == SEND) && (r_sel ? ready2_i : ready1_i);
  assign ready_o  = (r_st == IDLE);
  assign valid1_o = (r_st == SEND) && !r_sel;
  assign valid2_o = (r_st == SEND) && r_sel;
  assign word_o   = r_buf[NB_WORDS*WORD_W-1 -: WORD_W];
  assign idx_o    = r_idx;
  assign done_o   = r_done;
  // buffer shifts up one word per transfer so the head word is always the one on word_o
  always_comb begin
    w_st   = r_st;
    w_buf  = r_buf;
    w_sel  = r_sel;
    w_idx  = r_idx;
    w_done = 1'b0;
    if (r_st == IDLE && load_i) begin
      w_st  = SEND;
      w_buf = state_i;
      w_sel = sel_i;
      w_idx = 3'd0;
    end else if (w_xfer) begin
      w_buf  = r_buf << WORD_W;
      w_idx  = (r_idx == LAST) ? 3'd0 : r_idx + 3'd1;
      w_st   = (r_idx == LAST) ? IDLE : SEND;
      w_done = (r_idx == LAST);
    end
  end
  // state register with synchronous reset that also aborts a send in progress
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_st   <= IDLE;
      r_buf  <= '0;
      r_sel  <= 1'b0;
      r_idx  <= 3'd0;
      r_done <= 1'b0;
    end else begin
      r_st   <= w_st;
      r_buf  <= w_buf;
      r_sel  <= w_sel;
      r_idx  <= w_idx;
      r_done <= w_done;
    end
  end
endmodule

// File: tb/tb_state_word_demux.sv
// tb_state_word_demux: directed checks of the two-way state word streamer
module tb_state_word_demux;
  logic         clk = 1'b0;
  logic         reset_i = 1'b1, load_i = 1'b0, sel_i = 1'b0;
  logic [319:0] state_i = '0;
  logic         ready_o, valid1_o, valid2_o, done_o;
  logic         ready1_i = 1'b0, ready2_i = 1'b0;
  logic [63:0]  word_o;
  logic [2:0]   idx_o;
  int           n_asserts = 0, n_fail = 0;
  logic [63:0]  sw[5], tw[5];
  logic [319:0] s_vec, t_vec;
  logic         pat[4];
  int           k, cyc;

  state_word_demux dut (
    .clock_i(clk), .reset_i(reset_i), .load_i(load_i), .sel_i(sel_i),
    .state_i(state_i), .ready_o(ready_o), .word_o(word_o), .idx_o(idx_o),
    .valid1_o(valid1_o), .ready1_i(ready1_i), .valid2_o(valid2_o),
    .ready2_i(ready2_i), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [63:0] exp_w, input int i, input logic v1, input logic v2);
    chk({tag, "_word"}, word_o, exp_w);
    chk({tag, "_idx"}, 64'(idx_o), 64'(i));
    chk({tag, "_v1"}, 64'(valid1_o), 64'(v1));
    chk({tag, "_v2"}, 64'(valid2_o), 64'(v2));
    chk({tag, "_rdy"}, 64'(ready_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      sw[i] = {16{4'(i)}};
      tw[i] = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0101_0101;
      s_vec[319-64*i -: 64] = sw[i];
      t_vec[319-64*i -: 64] = tw[i];
    end
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    // 1: reset then idle
    tick;
    reset_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("idle_rdy", 64'(ready_o), 64'd1);
      chk("idle_v1", 64'(valid1_o), 64'd0);
      chk("idle_v2", 64'(valid2_o), 64'd0);
      chk("idle_done", 64'(done_o), 64'd0);
      if (i == 0) begin
        chk("rst_word", word_o, 64'd0);
        chk("rst_idx", 64'(idx_o), 64'd0);
      end
      tick;
    end
    // 2: stream to port 1 with ready held high
    ready1_i = 1'b1; sel_i = 1'b0; state_i = s_vec; load_i = 1'b1;
    tick;
    load_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_word("p1", sw[i], i, 1'b1, 1'b0);
      tick;
    end
    chk("p1_done", 64'(done_o), 64'd1);
    chk("p1_rdy", 64'(ready_o), 64'd1);
    chk("p1_v1_off", 64'(valid1_o), 64'd0);
    tick;
    chk("p1_done_pulse", 64'(done_o), 64'd0);
    // 3: stream to port 2 with stalls; port 1 ready is ignored
    sel_i = 1'b1; state_i = t_vec; load_i = 1'b1;
    tick;
    load_i = 1'b0; sel_i = 1'b0;
    k = 0; cyc = 0;
    while (k < 5 && cyc < 40) begin
      chk_word("p2", tw[k], k, 1'b0, 1'b1);
      ready2_i = pat[cyc % 4];
      tick;
      if (ready2_i) k++;
      cyc++;
    end
    ready2_i = 1'b0;
    chk("p2_count", 64'(k), 64'd5);
    chk("p2_cycles", 64'(cyc), 64'd9);
    chk("p2_done", 64'(done_o), 64'd1);
    chk("p2_rdy", 64'(ready_o), 64'd1);
    tick;
    // 4: loads during send ignored; load in the done cycle accepted
    sel_i = 1'b0; state_i = s_vec; load_i = 1'b1;
    tick;
    state_i = t_vec; sel_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_word("ign", sw[i], i, 1'b1, 1'b0);
      tick;
    end
    chk("b2b_done", 64'(done_o), 64'd1);
    chk("b2b_rdy", 64'(ready_o), 64'd1);
    sel_i = 1'b0;
    tick;
    load_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_word("b2b", tw[i], i, 1'b1, 1'b0);
      tick;
    end
    chk("b2b_done2", 64'(done_o), 64'd1);
    tick;
    // 5: reset mid-send aborts without done
    state_i = s_vec; load_i = 1'b1;
    tick;
    load_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_word("pre_rst", sw[i], i, 1'b1, 1'b0);
      tick;
    end
    reset_i = 1'b1;
    tick;
    reset_i = 1'b0;
    chk("abort_v1", 64'(valid1_o), 64'd0);
    chk("abort_rdy", 64'(ready_o), 64'd1);
    chk("abort_idx", 64'(idx_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    chk("abort_word", word_o, 64'd0);
    state_i = t_vec; load_i = 1'b1;
    tick;
    load_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_word("fresh", tw[i], i, 1'b1, 1'b0);
      tick;
    end
    chk("fresh_done", 64'(done_o), 64'd1);
    tick;
    // 6: reset beats load
    reset_i = 1'b1; load_i = 1'b1; state_i = s_vec;
    tick;
    reset_i = 1'b0; load_i = 1'b0;
    chk("rl_rdy", 64'(ready_o), 64'd1);
    chk("rl_v1", 64'(valid1_o), 64'd0);
    chk("rl_v2", 64'(valid2_o), 64'd0);
    tick;
    chk("rl_v1_b", 64'(valid1_o), 64'd0);
    chk("rl_word", word_o, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
